// File: rtl/two_of_five_pkg.sv
// Shared definitions for the 2-of-5 codeword datapath: state encoding,
// frame geometry and the codeword validity check.
package two_of_five_pkg;

  localparam int CODE_W     = 5;
  localparam int FRAME_BITS = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // A legal codeword has exactly two bits set.
  function automatic logic is_two_of_five(input logic [CODE_W-1:0] code);
    int ones;
    ones = 0;
    for (int i = 0; i < CODE_W; i++) begin
      ones = ones + int'(code[i]);
    end
    return (ones == 2);
  endfunction

endpackage

// File: rtl/two_of_five_serial_tx_bit_timer.sv
// Bit-period timer: counts clock cycles within one serial bit and flags the
// last cycle of the period. Held at zero while clear is asserted.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic wrap
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign wrap = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/two_of_five_serial_tx.sv
// Serial transmitter for 2-of-5 codewords: accepts one word per handshake,
// frames legal words as start/5 data/stop and counts rejected words.
module two_of_five_serial_tx
  import two_of_five_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ERR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              code_valid,
  output logic              code_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              code_err,
  output logic [ERR_W-1:0]  err_count
);

  tx_state_t                       state;
  logic [CODE_W-1:0]               shift_reg;
  logic [$clog2(FRAME_BITS)-1:0]   bit_idx;
  logic                            wrap;

  // The timer only runs inside a frame, so each bit period starts at zero.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .wrap (wrap)
  );

  assign code_ready = (state == IDLE);
  assign tx_busy    = (state != IDLE);
  assign frame_done = (state == STOP) && wrap;

  // tx is driven from the transition that enters each bit, so the line
  // changes exactly on bit boundaries with no decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      shift_reg <= '0;
      bit_idx   <= '0;
      code_err  <= 1'b0;
      err_count <= '0;
    end else begin
      code_err <= 1'b0;
      case (state)
        IDLE: begin
          if (code_valid) begin
            if (is_two_of_five(code)) begin
              state     <= START;
              shift_reg <= code;
              tx        <= 1'b0;
            end else begin
              code_err <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + 1'b1;
              end
            end
          end
        end
        START: begin
          if (wrap) begin
            state   <= DATA;
            bit_idx <= ($clog2(FRAME_BITS))'(CODE_W - 1);
            tx      <= shift_reg[CODE_W-1];
          end
        end
        DATA: begin
          if (wrap) begin
            if (bit_idx == '0) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx - 1'b1;
              tx      <= shift_reg[bit_idx - 1'b1];
            end
          end
        end
        STOP: begin
          if (wrap) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_of_five_serial_tx.sv
// Self-checking bench for two_of_five_serial_tx: three instances cover the
// default timing, a narrow saturating counter and one-cycle bits.
module tb_two_of_five_serial_tx;

  logic            clk;
  logic [2:0]      rst;
  logic [2:0]      valid;
  logic [2:0][4:0] code;

  logic ready0, tx0, busy0, done0, cerr0;
  logic ready1, tx1, busy1, done1, cerr1;
  logic ready2, tx2, busy2, done2, cerr2;
  logic [7:0] ecnt0;
  logic [1:0] ecnt1;
  logic [7:0] ecnt2;

  logic [2:0] readyv, txv, busyv, donev, cerrv;
  assign readyv = {ready2, ready1, ready0};
  assign txv    = {tx2, tx1, tx0};
  assign busyv  = {busy2, busy1, busy0};
  assign donev  = {done2, done1, done0};
  assign cerrv  = {cerr2, cerr1, cerr0};

  int total = 0;
  int bad   = 0;
  int model_err [3];

  two_of_five_serial_tx #(.CLKS_PER_BIT(4), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst[0]), .code(code[0]), .code_valid(valid[0]),
    .code_ready(ready0), .tx(tx0), .tx_busy(busy0), .frame_done(done0),
    .code_err(cerr0), .err_count(ecnt0));

  two_of_five_serial_tx #(.CLKS_PER_BIT(4), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst[1]), .code(code[1]), .code_valid(valid[1]),
    .code_ready(ready1), .tx(tx1), .tx_busy(busy1), .frame_done(done1),
    .code_err(cerr1), .err_count(ecnt1));

  two_of_five_serial_tx #(.CLKS_PER_BIT(1), .ERR_W(8)) dut2 (
    .clk(clk), .rst(rst[2]), .code(code[2]), .code_valid(valid[2]),
    .code_ready(ready2), .tx(tx2), .tx_busy(busy2), .frame_done(done2),
    .code_err(cerr2), .err_count(ecnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ecnt(input int d);
    case (d)
      0:       return ecnt0;
      1:       return {6'b0, ecnt1};
      default: return ecnt2;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one legal word and checks every cycle of its frame against the
  // ideal waveform, then decodes the line mid-bit and compares the word.
  task automatic run_frame(input int d, input logic [4:0] w, input int cpb);
    logic       fb [7];
    logic [4:0] dec;
    int         b;
    fb[0] = 1'b0;
    for (int i = 1; i <= 5; i++) fb[i] = w[5-i];
    fb[6] = 1'b1;
    dec = '0;
    total++;
    if (readyv[d] !== 1'b1) begin
      bad++; $display("[TB] FAIL ready_before_frame dut%0d: got %b expected 1", d, readyv[d]);
    end
    code[d]  = w;
    valid[d] = 1'b1;
    tick();
    for (int k = 0; k < 7*cpb; k++) begin
      b = k / cpb;
      total++;
      if (txv[d] !== fb[b]) begin
        bad++; $display("[TB] FAIL tx dut%0d word=%b cycle %0d: got %b expected %b", d, w, k, txv[d], fb[b]);
      end
      total++;
      if (busyv[d] !== 1'b1 || readyv[d] !== 1'b0) begin
        bad++; $display("[TB] FAIL busy_ready dut%0d cycle %0d: got busy=%b ready=%b expected busy=1 ready=0", d, k, busyv[d], readyv[d]);
      end
      total++;
      if (donev[d] !== (k == 7*cpb-1)) begin
        bad++; $display("[TB] FAIL frame_done dut%0d cycle %0d: got %b expected %b", d, k, donev[d], (k == 7*cpb-1));
      end
      total++;
      if (cerrv[d] !== 1'b0) begin
        bad++; $display("[TB] FAIL code_err_in_frame dut%0d cycle %0d: got %b expected 0", d, k, cerrv[d]);
      end
      if (k % cpb == cpb / 2 && b >= 1 && b <= 5) dec[5-b] = txv[d];
      code[d]  = 5'($urandom);
      valid[d] = (k == 7*cpb-1) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
    end
    valid[d] = 1'b0;
    total++;
    if (dec !== w) begin
      bad++; $display("[TB] FAIL decode dut%0d: got %b expected %b", d, dec, w);
    end
    total++;
    if (txv[d] !== 1'b1 || readyv[d] !== 1'b1 || busyv[d] !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_after_frame dut%0d: got tx=%b ready=%b busy=%b expected 1,1,0", d, txv[d], readyv[d], busyv[d]);
    end
  endtask

  task automatic send_invalid(input int d, input logic [4:0] w);
    int max_cnt;
    max_cnt = (d == 1) ? 3 : 255;
    if (model_err[d] < max_cnt) model_err[d]++;
    code[d]  = w;
    valid[d] = 1'b1;
    tick();
    valid[d] = 1'b0;
    total++;
    if (cerrv[d] !== 1'b1) begin
      bad++; $display("[TB] FAIL code_err_pulse dut%0d word=%b: got %b expected 1", d, w, cerrv[d]);
    end
    total++;
    if (ecnt(d) !== 8'(model_err[d])) begin
      bad++; $display("[TB] FAIL err_count dut%0d word=%b: got %0d expected %0d", d, w, ecnt(d), model_err[d]);
    end
    total++;
    if (txv[d] !== 1'b1 || readyv[d] !== 1'b1 || busyv[d] !== 1'b0) begin
      bad++; $display("[TB] FAIL invalid_idle dut%0d: got tx=%b ready=%b busy=%b expected 1,1,0", d, txv[d], readyv[d], busyv[d]);
    end
    tick();
    total++;
    if (cerrv[d] !== 1'b0) begin
      bad++; $display("[TB] FAIL code_err_clear dut%0d: got %b expected 0", d, cerrv[d]);
    end
  endtask

  task automatic test_reset();
    rst   = 3'b111;
    valid = 3'b000;
    code  = '0;
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (txv[d] !== 1'b1 || readyv[d] !== 1'b1 || busyv[d] !== 1'b0 ||
          donev[d] !== 1'b0 || cerrv[d] !== 1'b0 || ecnt(d) !== 8'd0) begin
        bad++; $display("[TB] FAIL reset_state dut%0d: got tx=%b ready=%b busy=%b done=%b err=%b cnt=%0d expected 1,1,0,0,0,0",
                        d, txv[d], readyv[d], busyv[d], donev[d], cerrv[d], ecnt(d));
      end
      model_err[d] = 0;
    end
    rst = 3'b000;
    tick();
  endtask

  task automatic test_single_frame();
    run_frame(0, 5'b00011, 4);
  endtask

  task automatic test_invalid();
    send_invalid(0, 5'b00111);
  endtask

  // Valid held high across two words; the line is decoded afterwards.
  task automatic test_back_to_back();
    logic       stream [$];
    logic [4:0] words [$];
    logic [4:0] w;
    int accepts, dones, i;
    logic gap_ok;
    accepts = 0; dones = 0; gap_ok = 1'b1;
    code[0]  = 5'b11000;
    valid[0] = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (valid[0] && readyv[0]) accepts++;
      tick();
      stream.push_back(txv[0]);
      if (donev[0]) dones++;
      total++;
      if (readyv[0] !== !busyv[0]) begin
        bad++; $display("[TB] FAIL ready_vs_busy cycle %0d: got ready=%b busy=%b expected complementary", c, readyv[0], busyv[0]);
      end
      if (accepts == 1) code[0] = 5'b10100;
      if (accepts >= 2) valid[0] = 1'b0;
    end
    i = 0;
    while (i < stream.size()) begin
      if (stream[i] == 1'b0 && i + 28 <= stream.size()) begin
        w = '0;
        for (int b = 1; b <= 5; b++) w[5-b] = stream[i + 4*b + 2];
        words.push_back(w);
        if (i + 28 < stream.size() && stream[i + 28] !== 1'b1) gap_ok = 1'b0;
        i = i + 28;
      end else begin
        i++;
      end
    end
    total++;
    if (dones != 2 || words.size() != 2) begin
      bad++; $display("[TB] FAIL b2b_frame_count: got done=%0d frames=%0d expected 2,2", dones, words.size());
    end else begin
      total++;
      if (words[0] !== 5'b11000 || words[1] !== 5'b10100) begin
        bad++; $display("[TB] FAIL b2b_words: got %b,%b expected 11000,10100", words[0], words[1]);
      end
    end
    total++;
    if (!gap_ok) begin
      bad++; $display("[TB] FAIL b2b_idle_gap: got low line after stop expected high");
    end
  endtask

  task automatic test_reset_mid_frame();
    code[0]  = 5'b01010;
    valid[0] = 1'b1;
    tick();
    valid[0] = 1'b0;
    repeat (9) tick();
    total++;
    if (busyv[0] !== 1'b1) begin
      bad++; $display("[TB] FAIL busy_before_abort: got %b expected 1", busyv[0]);
    end
    rst[0] = 1'b1;
    tick();
    total++;
    if (txv[0] !== 1'b1 || readyv[0] !== 1'b1 || busyv[0] !== 1'b0 || ecnt(0) !== 8'd0) begin
      bad++; $display("[TB] FAIL abort_state: got tx=%b ready=%b busy=%b cnt=%0d expected 1,1,0,0", txv[0], readyv[0], busyv[0], ecnt(0));
    end
    model_err[0] = 0;
    rst[0] = 1'b0;
    tick();
    run_frame(0, 5'b10001, 4);
  endtask

  task automatic test_saturation();
    logic [4:0] bad_words [5];
    bad_words = '{5'b00000, 5'b11111, 5'b00001, 5'b01111, 5'b10000};
    foreach (bad_words[k]) send_invalid(1, bad_words[k]);
  endtask

  task automatic test_fast_all_codes();
    logic [4:0] legal [10];
    legal = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
              5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
    foreach (legal[k]) run_frame(2, legal[k], 1);
    total++;
    if (ecnt(2) !== 8'd0) begin
      bad++; $display("[TB] FAIL fast_err_count: got %0d expected 0", ecnt(2));
    end
  endtask

  task automatic test_random();
    logic [4:0] w;
    for (int n = 0; n < 24; n++) begin
      w = 5'($urandom_range(0, 31));
      if ($countones(w) == 2) run_frame(0, w, 4);
      else                    send_invalid(0, w);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_invalid();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    test_fast_all_codes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
